// File: rtl/dbg_probe_ctrl.sv
// dbg_probe_ctrl: host debug initiator that steps/runs the CPU and streams PC, register and memory snapshots; define DBG_PROBE_HEADER_EN to prefix each response with a header word
module dbg_probe_ctrl #(
  parameter int DM_AW = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [DM_AW-1:0] cmd_addr,
  output logic             cpu_en,
  input  logic             cpu_halt,
  input  logic [31:0]      cpu_pc,
  output logic [4:0]       rf_req,
  input  logic [31:0]      rf_data,
  output logic [DM_AW-1:0] dm_addr,
  input  logic [31:0]      dm_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, STEP, RUN, RD, SEND} state_t;
  localparam logic [1:0] OP_STEP = 2'd0, OP_REGS = 2'd1, OP_MEM = 2'd2, OP_RUN = 2'd3;
  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [4:0]         rf_req_q, rf_req_d;
  logic [DM_AW-1:0]   dm_addr_q, dm_addr_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [31:0]        pay_word;
`ifdef DBG_PROBE_HEADER_EN
  logic               hdr_q, hdr_d;
  logic [31:0]        hdr_word;
  assign hdr_word = {8'hA5, 6'd0, op_q, (op_q == OP_STEP || op_q == OP_RUN) ? 16'd1 : 16'(count_q)};
`endif
  assign pay_word  = (op_q == OP_STEP || op_q == OP_RUN) ? cpu_pc : (op_q == OP_REGS) ? rf_data : dm_data;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign cpu_en    = (state_q == STEP || state_q == RUN) && !cpu_halt;
  assign out_valid = state_q == SEND;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign rf_req    = rf_req_q;
  assign dm_addr   = dm_addr_q;
  // next-state: count holds remaining steps in STEP, remaining words from RD onward
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    count_d    = count_q;
    rf_req_d   = rf_req_q;
    dm_addr_d  = dm_addr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
`ifdef DBG_PROBE_HEADER_EN
    hdr_d      = hdr_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d      = cmd_op;
        count_d   = cmd_arg;
        rf_req_d  = '0;
        dm_addr_d = cmd_addr;
`ifdef DBG_PROBE_HEADER_EN
        hdr_d     = 1'b1;
        state_d   = RD;
        if (cmd_op == OP_REGS) count_d = CNT_W'(32);
`else
        if (cmd_op == OP_REGS) begin
          state_d = RD;
          count_d = CNT_W'(32);
        end else if (cmd_op == OP_RUN) state_d = RUN;
        else if (cmd_arg == '0) begin
          state_d = (cmd_op == OP_STEP) ? RD : IDLE;
          count_d = CNT_W'(1);
        end else state_d = (cmd_op == OP_STEP) ? STEP : RD;
`endif
      end
      STEP: if (cpu_halt || count_q == CNT_W'(1)) begin
        state_d = RD;
        count_d = CNT_W'(1);
      end else count_d = count_q - CNT_W'(1);
      RUN: if (cpu_halt) begin
        state_d = RD;
        count_d = CNT_W'(1);
      end
      RD: begin
`ifdef DBG_PROBE_HEADER_EN
        out_data_d = hdr_q ? hdr_word : pay_word;
        out_last_d = hdr_q ? (op_q == OP_MEM && count_q == '0) : count_q == CNT_W'(1);
`else
        out_data_d = pay_word;
        out_last_d = count_q == CNT_W'(1);
`endif
        state_d    = SEND;
      end
      SEND: if (out_ready) begin
        if (out_last_q) state_d = IDLE;
`ifdef DBG_PROBE_HEADER_EN
        else if (hdr_q) begin
          hdr_d = 1'b0;
          if (op_q == OP_RUN) state_d = RUN;
          else if (op_q == OP_STEP && count_q != '0) state_d = STEP;
          else begin
            state_d = RD;
            if (op_q == OP_STEP) count_d = CNT_W'(1);
          end
        end
`endif
        else begin
          count_d   = count_q - CNT_W'(1);
          rf_req_d  = rf_req_q + 5'd1;
          dm_addr_d = dm_addr_q + DM_AW'(1);
          state_d   = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      count_q    <= '0;
      rf_req_q   <= '0;
      dm_addr_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
`ifdef DBG_PROBE_HEADER_EN
      hdr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      count_q    <= count_d;
      rf_req_q   <= rf_req_d;
      dm_addr_q  <= dm_addr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
`ifdef DBG_PROBE_HEADER_EN
      hdr_q      <= hdr_d;
`endif
    end
  end
endmodule
